// File: rtl/vec_mem_sequencer.sv
// MEM-stage data memory sequencer: splits scalar/vector loads and stores into
// DATA_W-wide beats, reassembles load data and stalls the pipeline meanwhile.
module vec_mem_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned VEC_W  = 128,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rmem,
    input  logic              wmem,
    input  logic              VF,
    input  logic [ADDR_W-1:0] addr,
    input  logic [VEC_W-1:0]  wdata,
    input  logic [3:0]        dest_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic [VEC_W-1:0]  rdata,
    output logic              rdata_valid,
    output logic [3:0]        dest_out,
    output logic              busy
);

    localparam int unsigned BEATS  = VEC_W / DATA_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned STEP   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_nxt;
    logic [BEAT_W-1:0] last_beat;
    logic              lat_vf;
    logic              lat_rd;
    logic [3:0]        lat_dest;
    logic [VEC_W-1:0]  lat_wdata;
    logic [VEC_W-1:0]  rdata_nxt;
    logic              req;
    logic              in_xfer;

    assign req       = rmem | wmem;
    assign in_xfer   = (state == READ) || (state == WRITE);
    assign beat_nxt  = beat + 1'b1;
    assign last_beat = lat_vf ? BEAT_W'(BEATS - 1) : '0;

    // Gated by rst so stall reads 0 while reset is held even if a request is present.
    assign stall = rst & (((state == IDLE) & req) | in_xfer);
    assign busy  = (state != IDLE);

    // First read beat clears the other lanes so a scalar load returns zero-extended data.
    always_comb begin
        rdata_nxt = (beat == '0) ? '0 : rdata;
        rdata_nxt[beat*DATA_W +: DATA_W] = mem_rdata;
    end

    // mem_addr is advanced by one word per beat, which equals base + beat*STEP modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat        <= '0;
            lat_vf      <= 1'b0;
            lat_rd      <= 1'b0;
            lat_dest    <= '0;
            lat_wdata   <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            dest_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rdata_valid <= 1'b0;
                    if (req) begin
                        state     <= wmem ? WRITE : READ;
                        beat      <= '0;
                        lat_vf    <= VF;
                        lat_rd    <= ~wmem;
                        lat_dest  <= dest_in;
                        lat_wdata <= wdata;
                        mem_addr  <= addr;
                        mem_wdata <= wmem ? wdata[DATA_W-1:0] : '0;
                        mem_re    <= ~wmem;
                        mem_we    <= wmem;
                    end
                end
                READ, WRITE: begin
                    if (mem_ready) begin
                        if (state == READ) begin
                            rdata <= rdata_nxt;
                        end
                        if (beat == last_beat) begin
                            state     <= DONE;
                            mem_re    <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= '0;
                            mem_wdata <= '0;
                            if (lat_rd) begin
                                rdata_valid <= 1'b1;
                                dest_out    <= lat_dest;
                            end
                        end else begin
                            beat     <= beat_nxt;
                            mem_addr <= mem_addr + ADDR_W'(STEP);
                            if (state == WRITE) begin
                                mem_wdata <= lat_wdata[beat_nxt*DATA_W +: DATA_W];
                            end
                        end
                    end
                end
                DONE: begin
                    rdata_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Randomized self-checking bench for vec_mem_sequencer against a word-addressed
// memory model and per-transaction expectations derived from the access rules.
module tb_vec_mem_sequencer;

    logic         clk;
    logic         rst;
    logic         rmem;
    logic         wmem;
    logic         VF;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   dest_in;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_re;
    logic         mem_we;
    logic [31:0]  mem_rdata;
    logic         mem_ready;
    logic         stall;
    logic [127:0] rdata;
    logic         rdata_valid;
    logic [3:0]   dest_out;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  mem_model [logic [31:0]];
    logic [127:0] last_rd;
    logic [3:0]   last_dst;

    vec_mem_sequencer #(.DATA_W(32), .VEC_W(128), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rmem(rmem), .wmem(wmem), .VF(VF), .addr(addr),
        .wdata(wdata), .dest_in(dest_in), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .dest_out(dest_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // One access from its IDLE request cycle through the DONE cycle.
    task automatic run_op(input bit rd, input bit wr, input bit vf, input logic [31:0] a,
                          input logic [127:0] wd, input logic [3:0] dst, input int wait_pct,
                          input int fbeat, input int fn);
        int           nb;
        int           k;
        int           forced;
        int           waits;
        bit           is_wr;
        bit           rdy;
        logic [31:0]  ea;
        logic [127:0] exp_rd;
        nb     = vf ? 4 : 1;
        is_wr  = wr;
        k      = 0;
        forced = 0;
        waits  = 0;
        exp_rd = '0;
        @(posedge clk); #1;
        rmem = rd; wmem = wr; VF = vf; addr = a; wdata = wd; dest_in = dst;
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        check_eq("req_stall", stall, 1);
        check_eq("req_busy", busy, 0);
        check_eq("req_strobe", {mem_re, mem_we}, 0);
        while (k < nb) begin
            @(posedge clk); #1;
            addr = $urandom; wdata = {$urandom, $urandom, $urandom, $urandom};
            dest_in = 4'($urandom); VF = 1'($urandom);
            ea  = a + 32'(4 * k);
            rdy = 1'b1;
            if (k == fbeat && forced < fn) begin
                rdy = 1'b0;
                forced++;
            end else if (waits < 6 && $urandom_range(99) < wait_pct) begin
                rdy = 1'b0;
                waits++;
            end
            mem_ready = rdy;
            mem_rdata = (rdy && !is_wr) ? mem_rd(ea) : $urandom;
            @(negedge clk);
            check_eq("beat_re", mem_re, !is_wr);
            check_eq("beat_we", mem_we, is_wr);
            check_eq("beat_addr", mem_addr, ea);
            if (is_wr) check_eq("beat_wdata", mem_wdata, wd[32*k +: 32]);
            check_eq("beat_stall", stall, 1);
            check_eq("beat_busy", busy, 1);
            check_eq("beat_valid", rdata_valid, 0);
            if (rdy) begin
                if (is_wr) mem_model[ea] = wd[32*k +: 32];
                else       exp_rd[32*k +: 32] = mem_rd(ea);
                k++;
            end
        end
        @(posedge clk); #1;
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clk);
        if (!is_wr) begin
            last_rd  = exp_rd;
            last_dst = dst;
        end
        check_eq("done_stall", stall, 0);
        check_eq("done_busy", busy, 1);
        check_eq("done_strobe", {mem_re, mem_we}, 0);
        check_eq("done_valid", rdata_valid, !is_wr);
        check_eq("done_rdata", rdata, last_rd);
        check_eq("done_dest", dest_out, last_dst);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        rmem = 1'b0; wmem = 1'b0;
        mem_ready = 1'($urandom);
        @(negedge clk);
        check_eq("idle_stall", stall, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_valid", rdata_valid, 0);
        check_eq("idle_strobe", {mem_re, mem_we}, 0);
        check_eq("idle_rdata", rdata, last_rd);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_out"},
                 {mem_addr, mem_wdata, mem_re, mem_we, stall, rdata_valid, dest_out, busy}, 0);
        check_eq({tag, "_rdata"}, rdata, 0);
    endtask

    initial begin
        rst = 1'b0; rmem = 1'b0; wmem = 1'b0; VF = 1'b0; addr = '0; wdata = '0;
        dest_in = '0; mem_rdata = '0; mem_ready = 1'b0;
        last_rd = '0; last_dst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Scalar load at 0x100
        mem_model[32'h100] = 32'hDEAD_BEEF;
        run_op(1, 0, 0, 32'h100, '0, 4'h5, 0, -1, 0);
        check_eq("scalar_ld_val", last_rd, 128'hDEAD_BEEF);
        idle_cycle();

        // Vector store at 0x200, then read it back
        run_op(0, 1, 1, 32'h200, 128'h44444444_33333333_22222222_11111111, 4'h2, 0, -1, 0);
        idle_cycle();
        run_op(1, 0, 1, 32'h200, '0, 4'h9, 0, -1, 0);
        check_eq("vec_rdback", last_rd, 128'h44444444_33333333_22222222_11111111);

        // Vector load back-to-back with two wait states on beat 1
        run_op(1, 0, 1, 32'h200, '0, 4'hC, 0, 1, 2);
        idle_cycle();

        // Address wrap
        run_op(1, 0, 1, 32'hFFFF_FFF8, '0, 4'h3, 0, -1, 0);
        idle_cycle();

        // Both rmem and wmem: write wins
        run_op(1, 1, 0, 32'h300, 128'h0BAD_F00D, 4'h7, 0, -1, 0);
        check_eq("both_mem", mem_rd(32'h300), 32'h0BAD_F00D);
        idle_cycle();

        // Reset during beat 2 of a vector load
        @(posedge clk); #1;
        rmem = 1'b1; wmem = 1'b0; VF = 1'b1; addr = 32'h400; dest_in = 4'hA;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("abort_pre_addr", mem_addr, 32'h408);
        check_eq("abort_pre_re", mem_re, 1);
        #1 rst = 1'b0;
        #1 check_all_zero("abort");
        last_rd = '0; last_dst = '0;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("abort_hold");
        end
        rmem = 1'b0;
        rst  = 1'b1;
        run_op(1, 0, 0, 32'h100, '0, 4'h6, 0, -1, 0);
        check_eq("post_reset_ld", last_rd, 128'hDEAD_BEEF);
        idle_cycle();

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            bit           r;
            bit           w;
            bit           v;
            logic [31:0]  a;
            logic [127:0] d;
            int           op;
            op = $urandom_range(0, 4);
            v  = 1'($urandom);
            r  = (op == 0 || op == 1 || op == 4);
            w  = (op == 2 || op == 3 || op == 4);
            if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            else                           a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
            d = {$urandom, $urandom, $urandom, $urandom};
            run_op(r, w, v, a, d, 4'($urandom), 30, -1, 0);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Sequences the MEM-stage data memory access for the vector ASIP.
- Accepts the scalar or vector load/store held in the EX/MEM pipeline register (rmem, wmem, VF, address, store data, destination).
- Splits 128-bit vector accesses into DATA_W-wide beats on the narrow memory port and reassembles load data.
- Holds `stall` high so the upstream pipeline registers freeze until the access completes.

Parameters:
DATA_W, 32, memory port data width in bits
VEC_W, 128, vector register width; BEATS = VEC_W/DATA_W (default 4)
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
rmem  in  1  load request from EX/MEM register
wmem  in  1  store request from EX/MEM register
VF  in  1  1 = vector access (BEATS beats), 0 = scalar (1 beat)
addr  in  ADDR_W  base byte address
wdata  in  VEC_W  store data; scalar uses bits [DATA_W-1:0]
dest_in  in  4  destination register index
mem_addr  out  ADDR_W  memory port address
mem_wdata  out  DATA_W  memory port write data
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1 during read
mem_ready  in  1  beat accepted/completed this cycle
stall  out  1  freeze IF..MEM pipeline registers
rdata  out  VEC_W  assembled load data
rdata_valid  out  1  one-cycle pulse, load data ready for writeback
dest_out  out  4  destination index accompanying rdata_valid
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; beat counter=0.
  - All outputs 0, including rdata, dest_out, mem_addr and mem_wdata.
  - Reset mid-transaction aborts immediately; mem_re/mem_we drop the same instant; no rdata_valid.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - A request is (rmem|wmem).
  - On request, latch addr, wdata, VF, dest_in and op. Go to WRITE if wmem=1 (write wins when both are set), else READ.
  - Beat counter := 0.
- READ/WRITE:
  - mem_addr = latched_addr + beat*(DATA_W/8), modulo 2^ADDR_W (wraps, no error).
  - READ drives mem_re=1; WRITE drives mem_we=1 with mem_wdata = latched wdata[beat*DATA_W +: DATA_W].
  - Strobes and address are held stable until mem_ready=1 (unlimited wait states).
  - On mem_ready in READ: rdata[beat*DATA_W +: DATA_W] := mem_rdata; on the first beat, all other bits := 0.
  - On mem_ready, if beat == last (BEATS-1 if VF, else 0), go to DONE; otherwise beat+1.
  - mem_ready outside READ/WRITE is ignored.
- DONE (one cycle):
  - stall=0, so the pipeline advances at the end of this cycle.
  - rdata_valid=1 and dest_out=latched dest only if op was read.
  - Request inputs are ignored (they still show the completing instruction); next state is IDLE unconditionally.
- stall (combinational) = (IDLE & (rmem|wmem)) | READ | WRITE.
- busy = state != IDLE.
- rdata and dest_out hold their values until the next load completes.
- Latency with mem_ready tied 1:
  - Scalar access: stall for 2 cycles, rdata_valid in cycle 3 (request cycle is cycle 1).
  - Vector access: stall for 5 cycles, rdata_valid in cycle 6.
- Back-to-back accesses: the next request is recognised in the IDLE cycle after DONE. There is one non-stalled DONE cycle between accesses, with no bubble insertion by this block.
- Input changes while stalled are ignored; the latched copies are used.

Test Plan:
- Scalar load, addr=0x100, mem_ready=1, memory returns 0xDEADBEEF:
  - mem_re=1 one cycle at 0x100.
  - rdata=0x...0000_DEADBEEF and rdata_valid pulse in cycle 3.
  - stall high in cycles 1–2.
- Vector store, addr=0x200, wdata=0x44444444_33333333_22222222_11111111, VF=1:
  - mem_we beats at 0x200/204/208/20C carry 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - No rdata_valid.
- Vector load with mem_ready low 2 cycles on beat 1:
  - mem_addr holds 0x204 for 3 cycles.
  - rdata lanes assembled correctly; stall covers all wait cycles; dest_out=dest_in at the pulse.
- Address wrap: vector load at addr=0xFFFFFFF8 → beats at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rmem=wmem=1 → WRITE sequence executed, no read strobes.
- Reset mid-transaction: assert rst=0 during beat 2 of a vector load.
  - Outputs immediately 0; mem_re=0; no rdata_valid.
  - After release, a new scalar load completes normally.
